// File: rtl/rtl_settings_pkg.sv
// Shared widths, descriptor types and helpers of the memory checker.
package rtl_settings_pkg;

    localparam int AMM_DATA_W  = 128;
    localparam int AMM_ADDR_W  = 32;
    localparam int AMM_BURST_W = 8;
    localparam     ADDR_TYPE   = "BYTE";
    localparam bit BYTE_ADDR   = (ADDR_TYPE == "BYTE");
    localparam int DATA_B_W    = AMM_DATA_W / 8;
    localparam int ADDR_B_W    = $clog2(DATA_B_W);
    // In byte mode the low address bits come from start_off
    localparam int ADDR_W      = BYTE_ADDR ? (AMM_ADDR_W - ADDR_B_W) : AMM_ADDR_W;

    typedef logic [DATA_B_W-1:0] mask_t;

    typedef enum logic { FIX_DATA = 1'b0, RND_DATA = 1'b1 } data_mode_t;
    typedef enum logic { WRITE_OP = 1'b0, READ_OP = 1'b1 } trans_op_t;

    typedef struct packed {
        logic [ADDR_W-1:0]      start_addr;
        logic [ADDR_B_W-1:0]    start_off;
        logic [ADDR_B_W-1:0]    end_off;
        logic [AMM_BURST_W-1:0] words_count;
        logic [7:0]             data_ptrn;
        data_mode_t             data_mode;
    } cmp_struct_t;

    typedef struct packed {
        trans_op_t              op;
        logic [ADDR_W-1:0]      start_addr;
        logic [ADDR_B_W-1:0]    start_off;
        logic [ADDR_B_W-1:0]    end_off;
        logic [AMM_BURST_W-1:0] words_count;
        logic [7:0]             data_ptrn;
        data_mode_t             data_mode;
    } trans_struct_t;

    typedef struct packed {
        mask_t first;
        mask_t last;
        mask_t merged;
    } be_masks_t;

    // first: bytes from start_off upward; last: bytes up to end_off
    function automatic be_masks_t byteenable_ptrn(input logic [ADDR_B_W-1:0] start_off,
                                                  input logic [ADDR_B_W-1:0] end_off);
        be_masks_t m;
        for (int i = 0; i < DATA_B_W; i++) begin
            m.first[i] = (i >= int'(start_off));
            m.last[i]  = (i <= int'(end_off));
        end
        m.merged = m.first & m.last;
        return m;
    endfunction

endpackage

// File: rtl/transmit_block_data_lfsr.sv
// 8-bit data pattern generator; load seeds it, adv steps it. Same sequence as compare_block.
module data_lfsr (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       adv_i,
    output logic [7:0] ptrn_o
);

    logic [7:0] ptrn_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptrn_reg <= '0;
        end else if (load_i) begin
            ptrn_reg <= load_val_i;
        end else if (adv_i) begin
            ptrn_reg <= {ptrn_reg[6:0], ptrn_reg[6] ^ ptrn_reg[1] ^ ptrn_reg[0]};
        end
    end

    assign ptrn_o = ptrn_reg;

endmodule

// File: rtl/transmit_block.sv
// Avalon-MM burst master: turns one descriptor at a time into a write or read burst.
// Optional statistics counters are built when TRANS_STAT_EN is defined.
module transmit_block
    import rtl_settings_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   test_start_i,
    input  logic                   trans_valid_i,
    input  trans_struct_t          trans_struct_i,
    output logic                   trans_ready_o,
    input  logic                   cmp_error_i,
    output logic [AMM_ADDR_W-1:0]  address_o,
    output logic                   write_o,
    output logic                   read_o,
    output logic [AMM_DATA_W-1:0]  writedata_o,
    output logic [DATA_B_W-1:0]    byteenable_o,
    output logic [AMM_BURST_W-1:0] burstcount_o,
    input  logic                   waitrequest_i,
    output logic                   cmp_en_o,
    output cmp_struct_t            cmp_struct_o,
    output logic                   trans_busy_o,
    output logic [31:0]            wr_cnt_o,
    output logic [31:0]            rd_cnt_o
);

    typedef enum logic [1:0] { IDLE_S, LOAD_S, WRITE_S, READ_S } state_t;

    state_t                 state_reg, state_next;
    trans_struct_t          desc_reg;
    logic [AMM_BURST_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic                   first_beat_reg, first_beat_next;
    be_masks_t              masks_reg, masks_calc;
    logic [AMM_ADDR_W-1:0]  address_reg, address_calc;
    logic [AMM_BURST_W-1:0] burstcount_reg;
    logic                   stop_reg;
    logic                   cmp_en_reg;
    cmp_struct_t            cmp_struct_reg;
    logic [7:0]             ptrn;
    mask_t                  be_sel;
    logic                   accept, beat_acc, last_beat, rd_acc, lfsr_load, lfsr_adv;

    assign trans_ready_o = (state_reg == IDLE_S) && !stop_reg;
    assign accept        = trans_valid_i && trans_ready_o;
    assign beat_acc      = (state_reg == WRITE_S) && !waitrequest_i;
    assign rd_acc        = (state_reg == READ_S) && !waitrequest_i;
    assign last_beat     = (beat_cnt_reg == '0);
    assign lfsr_load     = (state_reg == LOAD_S);
    assign lfsr_adv      = beat_acc && (desc_reg.data_mode == RND_DATA);

    always_comb begin
        state_next      = state_reg;
        beat_cnt_next   = beat_cnt_reg;
        first_beat_next = first_beat_reg;
        case (state_reg)
            IDLE_S: if (accept) state_next = LOAD_S;
            LOAD_S: begin
                state_next      = (desc_reg.op == WRITE_OP) ? WRITE_S : READ_S;
                beat_cnt_next   = desc_reg.words_count;
                first_beat_next = 1'b1;
            end
            WRITE_S: if (beat_acc) begin
                first_beat_next = 1'b0;
                if (last_beat) state_next = IDLE_S;
                else           beat_cnt_next = beat_cnt_reg - 1'b1;
            end
            READ_S: if (!waitrequest_i) state_next = IDLE_S;
            default: state_next = IDLE_S;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE_S;
            beat_cnt_reg   <= '0;
            first_beat_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            beat_cnt_reg   <= beat_cnt_next;
            first_beat_reg <= first_beat_next;
        end
    end

    // Descriptor contents are don't-care after reset, so no reset term
    always_ff @(posedge clk_i) begin
        if (accept) desc_reg <= trans_struct_i;
    end

    generate
        if (BYTE_ADDR) begin : g_byte_addr
            assign address_calc = {desc_reg.start_addr, desc_reg.start_off};
            assign masks_calc   = byteenable_ptrn(desc_reg.start_off, desc_reg.end_off);
        end else begin : g_word_addr
            assign address_calc = desc_reg.start_addr;
            assign masks_calc   = '1;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            address_reg    <= '0;
            burstcount_reg <= '0;
            masks_reg      <= '0;
        end else if (state_reg == LOAD_S) begin
            address_reg    <= address_calc;
            burstcount_reg <= desc_reg.words_count + AMM_BURST_W'(1);
            masks_reg      <= masks_calc;
        end
    end

    // Sticky stop: an error lets the running burst finish but blocks new descriptors
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)             stop_reg <= 1'b0;
        else if (test_start_i) stop_reg <= 1'b0;
        else if (cmp_error_i)  stop_reg <= 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmp_en_reg     <= 1'b0;
            cmp_struct_reg <= '0;
        end else begin
            cmp_en_reg <= rd_acc;
            if (rd_acc) begin
                cmp_struct_reg.start_addr  <= desc_reg.start_addr;
                cmp_struct_reg.start_off   <= desc_reg.start_off;
                cmp_struct_reg.end_off     <= desc_reg.end_off;
                cmp_struct_reg.words_count <= desc_reg.words_count;
                cmp_struct_reg.data_ptrn   <= desc_reg.data_ptrn;
                cmp_struct_reg.data_mode   <= desc_reg.data_mode;
            end
        end
    end

    data_lfsr u_data_lfsr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (lfsr_load),
        .load_val_i (desc_reg.data_ptrn),
        .adv_i      (lfsr_adv),
        .ptrn_o     (ptrn)
    );

    always_comb begin
        be_sel = '1;
        if (desc_reg.words_count == '0) be_sel = masks_reg.merged;
        else if (first_beat_reg)        be_sel = masks_reg.first;
        else if (last_beat)             be_sel = masks_reg.last;
    end

    assign write_o      = (state_reg == WRITE_S);
    assign read_o       = (state_reg == READ_S);
    assign address_o    = address_reg;
    assign burstcount_o = burstcount_reg;
    assign byteenable_o = write_o ? be_sel : (read_o ? '1 : '0);
    assign cmp_en_o     = cmp_en_reg;
    assign cmp_struct_o = cmp_struct_reg;
    assign trans_busy_o = (state_reg != IDLE_S);

    genvar gi;
    generate
        for (gi = 0; gi < DATA_B_W; gi++) begin : g_wdata
            assign writedata_o[gi*8 +: 8] = write_o ? ptrn : 8'h00;
        end
    endgenerate

`ifdef TRANS_STAT_EN
    logic [31:0] wr_cnt_reg, rd_cnt_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_cnt_reg <= '0;
            rd_cnt_reg <= '0;
        end else if (test_start_i) begin
            wr_cnt_reg <= '0;
            rd_cnt_reg <= '0;
        end else begin
            if (beat_acc && last_beat && (wr_cnt_reg != 32'hFFFF_FFFF)) wr_cnt_reg <= wr_cnt_reg + 32'd1;
            if (rd_acc && (rd_cnt_reg != 32'hFFFF_FFFF))                rd_cnt_reg <= rd_cnt_reg + 32'd1;
        end
    end

    assign wr_cnt_o = wr_cnt_reg;
    assign rd_cnt_o = rd_cnt_reg;
`else
    assign wr_cnt_o = '0;
    assign rd_cnt_o = '0;
`endif

endmodule

// File: tb/tb_transmit_block.sv
// Scoreboard bench for transmit_block: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_transmit_block;
    import rtl_settings_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst, test_start, trans_valid, cmp_error, waitrequest;
    trans_struct_t          trans_struct;
    logic                   trans_ready, write, read, cmp_en, trans_busy;
    logic [AMM_ADDR_W-1:0]  address;
    logic [AMM_DATA_W-1:0]  writedata;
    logic [DATA_B_W-1:0]    byteenable;
    logic [AMM_BURST_W-1:0] burstcount;
    cmp_struct_t            cmp_struct;
    logic [31:0]            wr_cnt, rd_cnt;

    always #5 clk = ~clk;

    transmit_block dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .test_start_i   (test_start),
        .trans_valid_i  (trans_valid),
        .trans_struct_i (trans_struct),
        .trans_ready_o  (trans_ready),
        .cmp_error_i    (cmp_error),
        .address_o      (address),
        .write_o        (write),
        .read_o         (read),
        .writedata_o    (writedata),
        .byteenable_o   (byteenable),
        .burstcount_o   (burstcount),
        .waitrequest_i  (waitrequest),
        .cmp_en_o       (cmp_en),
        .cmp_struct_o   (cmp_struct),
        .trans_busy_o   (trans_busy),
        .wr_cnt_o       (wr_cnt),
        .rd_cnt_o       (rd_cnt)
    );

    typedef struct {
        logic [AMM_ADDR_W-1:0]  addr;
        logic [AMM_BURST_W-1:0] burst;
        logic [7:0]             data_byte;
        logic [DATA_B_W-1:0]    be;
    } beat_t;

    beat_t       wq[$];
    beat_t       rq[$];
    cmp_struct_t cq[$];
    int          n_vec = 0;
    int          n_fail = 0;
    logic        rd_prev = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [AMM_DATA_W-1:0] repl(input logic [7:0] b);
        logic [AMM_DATA_W-1:0] r;
        for (int i = 0; i < DATA_B_W; i++) r[i*8 +: 8] = b;
        return r;
    endfunction

    function automatic logic [31:0] stat(input int v);
`ifdef TRANS_STAT_EN
        return 32'(v);
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    function automatic trans_struct_t mk(input trans_op_t op, input logic [ADDR_W-1:0] a,
                                         input logic [ADDR_B_W-1:0] so, input logic [ADDR_B_W-1:0] eo,
                                         input logic [AMM_BURST_W-1:0] wc, input logic [7:0] p,
                                         input data_mode_t m);
        trans_struct_t t;
        t.op = op; t.start_addr = a; t.start_off = so; t.end_off = eo;
        t.words_count = wc; t.data_ptrn = p; t.data_mode = m;
        return t;
    endfunction

    task automatic push_wr(input logic [AMM_ADDR_W-1:0] a, input logic [AMM_BURST_W-1:0] bc,
                           input logic [7:0] d, input logic [DATA_B_W-1:0] be);
        beat_t b;
        b.addr = a; b.burst = bc; b.data_byte = d; b.be = be;
        wq.push_back(b);
    endtask

    // Monitor: samples on the falling edge, where outputs and waitrequest are both settled
    always @(negedge clk) begin
        beat_t e;
        cmp_struct_t c;
        if (rst) begin
            rd_prev = 1'b0;
        end else begin
            if (rd_prev || cmp_en) check("cmp_en_timing", 128'(cmp_en), 128'(rd_prev));
            if (cmp_en) begin
                if (cq.size() == 0) check("cmp_unexpected", 128'(cmp_en), 128'd0);
                else begin
                    c = cq.pop_front();
                    check("cmp_struct", 128'(cmp_struct), 128'(c));
                end
            end
            rd_prev = read && !waitrequest;
            if (write) begin
                if (wq.size() == 0) check("wr_unexpected", 128'(write), 128'd0);
                else begin
                    e = wq[0];
                    check("wr_addr", 128'(address), 128'(e.addr));
                    check("wr_burst", 128'(burstcount), 128'(e.burst));
                    check("wr_data", writedata, repl(e.data_byte));
                    check("wr_be", 128'(byteenable), 128'(e.be));
                    if (!waitrequest) wq.delete(0);
                end
            end
            if (read) begin
                if (rq.size() == 0) check("rd_unexpected", 128'(read), 128'd0);
                else begin
                    e = rq[0];
                    check("rd_addr", 128'(address), 128'(e.addr));
                    check("rd_burst", 128'(burstcount), 128'(e.burst));
                    if (!waitrequest) rq.delete(0);
                end
            end
        end
    end

    // Called one step after a rising edge; returns one step after the accepting edge
    task automatic issue(input trans_struct_t d);
        int  n = 0;
        logic acc = 1'b0;
        trans_struct = d;
        trans_valid  = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = trans_ready;
            @(posedge clk); #1;
            n++;
            if (!acc && n > 50) begin
                check("accept_timeout", 128'(n), 128'd0);
                acc = 1'b1;
            end
        end
        trans_valid = 1'b0;
    endtask

    // Drives waitrequest/cmp_error per presented command until nbeats are accepted
    task automatic run_burst(input int nbeats, input int stall_beat, input int stall_cyc,
                             input int err_beat, input bit chk_lat);
        int beat = 0, st = 0, cyc = 0;
        bit done = 1'b0, lat = chk_lat;
        while (!done) begin
            cmp_error = 1'b0;
            if (write || read) begin
                if (lat) begin
                    check("first_cmd_latency", 128'(cyc), 128'd1);
                    lat = 1'b0;
                end
                cmp_error = (beat == err_beat);
                if (beat == stall_beat && st < stall_cyc) begin
                    waitrequest = 1'b1;
                    st++;
                end else begin
                    waitrequest = 1'b0;
                    beat++;
                    if (beat == nbeats) done = 1'b1;
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (!done && cyc > 200) begin
                check("burst_timeout", 128'(beat), 128'(nbeats));
                done = 1'b1;
            end
        end
        waitrequest = 1'b0;
        cmp_error   = 1'b0;
    endtask

    initial begin
        cmp_struct_t ec;
        rst = 1'b1; test_start = 1'b0; trans_valid = 1'b0; cmp_error = 1'b0; waitrequest = 1'b0;
        trans_struct = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_write", 128'(write), 128'd0);
        check("rst_read", 128'(read), 128'd0);
        check("rst_cmp_en", 128'(cmp_en), 128'd0);
        check("rst_busy", 128'(trans_busy), 128'd0);
        check("rst_address", 128'(address), 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", 128'(trans_ready), 128'd1);

        // Full-word 4-beat fixed-pattern write
        for (int i = 0; i < 4; i++) push_wr(32'h100, 8'd4, 8'hA5, 16'hFFFF);
        issue(mk(WRITE_OP, 28'h10, 4'd0, 4'd15, 8'd3, 8'hA5, FIX_DATA));
        check("busy_after_accept", 128'(trans_busy), 128'd1);
        run_burst(4, -1, 0, -1, 1'b1);
        check("wq_empty_t1", 128'(wq.size()), 128'd0);
        check("wr_cnt_t1", 128'(wr_cnt), 128'(stat(1)));
        check("idle_busy_t1", 128'(trans_busy), 128'd0);

        // Single-beat burst uses the merged mask
        push_wr(32'h203, 8'd1, 8'h3C, 16'h03F8);
        issue(mk(WRITE_OP, 28'h20, 4'd3, 4'd9, 8'd0, 8'h3C, FIX_DATA));
        run_burst(1, -1, 0, -1, 1'b0);
        check("wq_empty_t2", 128'(wq.size()), 128'd0);

        // Three beats: first mask, all ones, last mask
        push_wr(32'h213, 8'd3, 8'h5A, 16'hFFF8);
        push_wr(32'h213, 8'd3, 8'h5A, 16'hFFFF);
        push_wr(32'h213, 8'd3, 8'h5A, 16'h03FF);
        issue(mk(WRITE_OP, 28'h21, 4'd3, 4'd9, 8'd2, 8'h5A, FIX_DATA));
        run_burst(3, -1, 0, -1, 1'b0);
        check("wq_empty_t3", 128'(wq.size()), 128'd0);

        // Random pattern seeded 0x01, stalled two cycles on the second beat
        push_wr(32'h300, 8'd3, 8'h01, 16'hFFFF);
        push_wr(32'h300, 8'd3, 8'h03, 16'hFFFF);
        push_wr(32'h300, 8'd3, 8'h06, 16'hFFFF);
        issue(mk(WRITE_OP, 28'h30, 4'd0, 4'd15, 8'd2, 8'h01, RND_DATA));
        run_burst(3, 1, 2, -1, 1'b0);
        check("wq_empty_t4", 128'(wq.size()), 128'd0);

        // Eight-word read: one command, then a compare push
        begin
            beat_t r;
            r.addr = 32'h402; r.burst = 8'd8; r.data_byte = 8'h00; r.be = '1;
            rq.push_back(r);
        end
        ec.start_addr = 28'h40; ec.start_off = 4'd2; ec.end_off = 4'd13;
        ec.words_count = 8'd7; ec.data_ptrn = 8'h77; ec.data_mode = RND_DATA;
        cq.push_back(ec);
        issue(mk(READ_OP, 28'h40, 4'd2, 4'd13, 8'd7, 8'h77, RND_DATA));
        run_burst(1, -1, 0, -1, 1'b1);
        @(posedge clk); #1;
        check("rq_empty_t5", 128'(rq.size()), 128'd0);
        check("cq_empty_t5", 128'(cq.size()), 128'd0);
        check("rd_cnt_t5", 128'(rd_cnt), 128'(stat(1)));

        // Compare error during beat 2: burst completes, then stop holds off new work
        for (int i = 0; i < 4; i++) push_wr(32'h500, 8'd4, 8'hC3, 16'hFFFF);
        issue(mk(WRITE_OP, 28'h50, 4'd0, 4'd15, 8'd3, 8'hC3, FIX_DATA));
        run_burst(4, -1, 0, 1, 1'b0);
        check("wq_empty_t6", 128'(wq.size()), 128'd0);
        check("wr_cnt_t6", 128'(wr_cnt), 128'(stat(5)));
        trans_struct = mk(WRITE_OP, 28'h55, 4'd0, 4'd15, 8'd0, 8'h99, FIX_DATA);
        trans_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stop_ready", 128'(trans_ready), 128'd0);
            check("stop_busy", 128'(trans_busy), 128'd0);
            @(posedge clk); #1;
        end
        trans_valid = 1'b0;
        test_start  = 1'b1;
        @(posedge clk); #1;
        test_start = 1'b0;
        check("ready_after_start", 128'(trans_ready), 128'd1);
        check("wr_cnt_cleared", 128'(wr_cnt), 128'd0);
        check("rd_cnt_cleared", 128'(rd_cnt), 128'd0);

        // Asynchronous reset in the middle of an eight-beat write
        for (int i = 0; i < 8; i++) push_wr(32'h600, 8'd8, 8'h11, 16'hFFFF);
        issue(mk(WRITE_OP, 28'h60, 4'd0, 4'd15, 8'd7, 8'h11, FIX_DATA));
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_rst_write", 128'(write), 128'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_write", 128'(write), 128'd0);
        check("mid_rst_read", 128'(read), 128'd0);
        check("mid_rst_cmp_en", 128'(cmp_en), 128'd0);
        check("mid_rst_busy", 128'(trans_busy), 128'd0);
        check("mid_rst_wr_cnt", 128'(wr_cnt), 128'd0);
        check("mid_rst_rd_cnt", 128'(rd_cnt), 128'd0);
        check("beats_before_rst", 128'(wq.size()), 128'd6);
        wq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 128'(trans_ready), 128'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
